// File: rtl/svm_test_packer_if.sv
// Byte-in / word-out bundle for the SVM test-vector packer.
// The packer uses the master modport; the feeder/core side uses slave. Macro: SVM_TEST_PACKER_FLUSH_EN adds flush.
interface svm_test_packer_if #(
  parameter int CNT_W = 5
);
  logic [7:0]       din;
  logic             din_valid;
  logic             din_ready;
  logic [31:0]      test;
  logic             test_valid;
  logic             test_ready;
  logic [CNT_W-1:0] word_cnt;
  logic             vec_done;
`ifdef SVM_TEST_PACKER_FLUSH_EN
  logic             flush;
`endif

  modport master (
    input  din, din_valid, test_ready,
`ifdef SVM_TEST_PACKER_FLUSH_EN
    input  flush,
`endif
    output din_ready, test, test_valid, word_cnt, vec_done
  );

  modport slave (
    output din, din_valid, test_ready,
`ifdef SVM_TEST_PACKER_FLUSH_EN
    output flush,
`endif
    input  din_ready, test, test_valid, word_cnt, vec_done
  );
endinterface

// File: rtl/svm_test_packer.sv
// Packs a byte stream little-endian into 32-bit words for the SVM core, counts words per vector.
// Optional zero-padded partial-word flush when SVM_TEST_PACKER_FLUSH_EN is defined.
module svm_test_packer #(
  parameter int WORDS_PER_VECTOR = 32,
  parameter int CNT_W            = 5
) (
  input  logic               clk,
  input  logic               rst,
  svm_test_packer_if.master  bus
);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_VECTOR - 1);

  logic [1:0]       byte_cnt_reg, byte_cnt_next;
  logic [23:0]      asm_reg, asm_next;
  logic [31:0]      out_word_reg, out_word_next;
  logic             out_full_reg, out_full_next;
  logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;
  logic             vec_done_reg, vec_done_next;
  logic             handoff, accept, word_load, din_ready_c, stall_4th;

  assign handoff   = out_full_reg & bus.test_ready;
  assign stall_4th = (byte_cnt_reg == 2'd3) & out_full_reg & ~bus.test_ready;
  assign accept    = bus.din_valid & din_ready_c;
  assign word_load = accept & (byte_cnt_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign asm_next[8*gi +: 8] = (accept && byte_cnt_reg == 2'(gi)) ? bus.din : asm_reg[8*gi +: 8];
    end
  endgenerate

`ifdef SVM_TEST_PACKER_FLUSH_EN
  logic        flush_pend_reg, flush_pend_next;
  logic        flush_load;
  logic [31:0] pad_word;

  // Lanes at or above byte_cnt may hold stale bytes from an earlier word.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pad
      assign pad_word[8*gi +: 8] = (2'(gi) < byte_cnt_reg) ? asm_reg[8*gi +: 8] : 8'h00;
    end
  endgenerate
  assign pad_word[31:24] = 8'h00;

  assign flush_load  = flush_pend_reg & (~out_full_reg | bus.test_ready);
  assign din_ready_c = rst & ~stall_4th & ~flush_pend_reg;
`else
  assign din_ready_c = rst & ~stall_4th;
`endif

  always_comb begin
    byte_cnt_next = byte_cnt_reg;
    out_word_next = out_word_reg;
    out_full_next = out_full_reg;
    word_cnt_next = word_cnt_reg;
    vec_done_next = 1'b0;
`ifdef SVM_TEST_PACKER_FLUSH_EN
    flush_pend_next = flush_pend_reg;
`endif
    // Two-bit counter wraps 3->0 exactly when the word completes.
    if (accept)
      byte_cnt_next = byte_cnt_reg + 2'd1;
    if (handoff) begin
      out_full_next = 1'b0;
      if (word_cnt_reg == LAST_WORD) begin
        word_cnt_next = '0;
        vec_done_next = 1'b1;
      end else begin
        word_cnt_next = word_cnt_reg + CNT_W'(1);
      end
    end
    if (word_load) begin
      out_word_next = {bus.din, asm_reg};
      out_full_next = 1'b1;
    end
`ifdef SVM_TEST_PACKER_FLUSH_EN
    if (flush_load) begin
      out_word_next   = pad_word;
      out_full_next   = 1'b1;
      byte_cnt_next   = 2'd0;
      flush_pend_next = 1'b0;
    end else if (bus.flush && !flush_pend_reg && byte_cnt_next != 2'd0) begin
      flush_pend_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_reg <= 2'd0;
      asm_reg      <= 24'd0;
      out_word_reg <= 32'd0;
      out_full_reg <= 1'b0;
      word_cnt_reg <= '0;
      vec_done_reg <= 1'b0;
    end else begin
      byte_cnt_reg <= byte_cnt_next;
      asm_reg      <= asm_next;
      out_word_reg <= out_word_next;
      out_full_reg <= out_full_next;
      word_cnt_reg <= word_cnt_next;
      vec_done_reg <= vec_done_next;
    end
  end

`ifdef SVM_TEST_PACKER_FLUSH_EN
  always_ff @(posedge clk) begin
    if (!rst) flush_pend_reg <= 1'b0;
    else      flush_pend_reg <= flush_pend_next;
  end
`endif

  assign bus.din_ready  = din_ready_c;
  assign bus.test       = out_word_reg;
  assign bus.test_valid = out_full_reg;
  assign bus.word_cnt   = word_cnt_reg;
  assign bus.vec_done   = vec_done_reg;
endmodule
